// File: rtl/rca_multiword_sequencer_if.sv
// Valid/ready operand and result bundle for the multi-word ripple-carry sequencer.
interface rca_multiword_sequencer_if #(
    parameter int TOTAL_WIDTH = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [TOTAL_WIDTH-1:0] a;
    logic [TOTAL_WIDTH-1:0] b;
    logic                   cin;
    logic                   sub;
    logic                   out_valid;
    logic                   out_ready;
    logic [TOTAL_WIDTH-1:0] sum;
    logic                   cout;
    logic                   overflow;
    logic                   busy;

    // Producer/consumer side.
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, busy
    );

    // Sequencer side.
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow, busy
    );
endinterface

// File: rtl/rca_multiword_sequencer.sv
// Wide add/subtract computed one CHUNK_WIDTH slice per clock, LSB first,
// with the inter-chunk carry held in a flop between cycles.
module rca_multiword_sequencer #(
    parameter int TOTAL_WIDTH = 16,
    parameter int CHUNK_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    rca_multiword_sequencer_if.slave   bus
);
    localparam int NUM_CHUNKS = TOTAL_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);
    localparam int MSB        = TOTAL_WIDTH - 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]             state;
    logic [IDX_W-1:0]       idx;
    logic                   carry;
    logic [TOTAL_WIDTH-1:0] op_a;
    logic [TOTAL_WIDTH-1:0] op_b;
    logic [TOTAL_WIDTH-1:0] sum_r;
    logic                   cout_r;
    logic                   ovf_r;

    logic [31:0]            base;
    logic [CHUNK_WIDTH-1:0] a_chunk;
    logic [CHUNK_WIDTH-1:0] b_chunk;
    logic [CHUNK_WIDTH:0]   slice;

    // One narrow ripple-carry slice; carry-out lands in the top bit.
    function automatic logic [CHUNK_WIDTH:0] slice_add(
        input logic [CHUNK_WIDTH-1:0] x,
        input logic [CHUNK_WIDTH-1:0] y,
        input logic                   c
    );
        return {1'b0, x} + {1'b0, y} + {{CHUNK_WIDTH{1'b0}}, c};
    endfunction

    // Select the current chunk of both operands and run it through the slice.
    always_comb begin
        base    = 32'(idx) * 32'(CHUNK_WIDTH);
        a_chunk = op_a[base +: CHUNK_WIDTH];
        b_chunk = op_b[base +: CHUNK_WIDTH];
        slice   = slice_add(a_chunk, b_chunk, carry);
    end

    // Sequencer FSM: accept in IDLE, one chunk per RUN cycle, hold result in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        op_a  <= bus.a;
                        // Subtract is A + ~B + 1; the +1 rides in as the initial carry.
                        op_b  <= bus.sub ? ~bus.b : bus.b;
                        carry <= bus.sub | bus.cin;
                        idx   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_r[base +: CHUNK_WIDTH] <= slice[CHUNK_WIDTH-1:0];
                    carry <= slice[CHUNK_WIDTH];
                    if (idx == LAST_IDX) begin
                        // Last chunk carries the result MSB and the final carry-out.
                        cout_r <= slice[CHUNK_WIDTH];
                        ovf_r  <= (op_a[MSB] == op_b[MSB]) &&
                                  (slice[CHUNK_WIDTH-1] != op_a[MSB]);
                        idx    <= '0;
                        state  <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.overflow  = ovf_r;
endmodule

// File: tb/tb_rca_multiword_sequencer.sv
// Bench for rca_multiword_sequencer: directed operations with literal
// expectations plus a cycle-level reference model of the handshake and result.
module tb_rca_multiword_sequencer;
    localparam int W  = 16;
    localparam int NC = 4;

    logic clk;
    logic rst;

    rca_multiword_sequencer_if #(.TOTAL_WIDTH(W)) bus ();

    rca_multiword_sequencer #(.TOTAL_WIDTH(W), .CHUNK_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: an op accepted in idle produces its result NC edges later
    // and stays until out_ready; the result is plain full-width arithmetic.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    int           m_rem  = 0;
    logic [W-1:0] m_sum  = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf  = 1'b0;
    logic [W-1:0] p_sum;
    logic         p_cout;
    logic         p_ovf;

    always @(posedge clk) begin
        longint sa, sb, s;
        longint ua, ub, u;
        cyc++;
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_rem = 0;
            m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
        end else if (m_done) begin
            if (bus.out_ready) begin
                m_done = 1'b0;
                m_busy = 1'b0;
            end
        end else if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin
                m_done = 1'b1;
                m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
            end
        end else if (bus.in_valid) begin
            m_busy = 1'b1;
            m_rem  = NC;
            sa = longint'($signed(bus.a));
            sb = longint'($signed(bus.b));
            ua = longint'(bus.a);
            ub = longint'(bus.b);
            if (bus.sub) begin
                s = sa - sb;
                u = ua - ub;
                p_cout = (ua >= ub);
            end else begin
                s = sa + sb + longint'(bus.cin);
                u = ua + ub + longint'(bus.cin);
                p_cout = (u >= (longint'(1) << W));
            end
            p_sum = u[W-1:0];
            p_ovf = (s > ((longint'(1) << (W-1)) - 1)) || (s < -(longint'(1) << (W-1)));
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("m_in_ready",  32'(bus.in_ready),  32'(!m_busy));
            chk("m_out_valid", 32'(bus.out_valid), 32'(m_done));
            chk("m_busy",      32'(bus.busy),      32'(m_busy));
            if (m_done || !m_busy) begin
                chk("m_sum",      32'(bus.sum),      32'(m_sum));
                chk("m_cout",     32'(bus.cout),     32'(m_cout));
                chk("m_overflow", 32'(bus.overflow), 32'(m_ovf));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                            input logic icin, input logic isub);
        bus.in_valid = 1'b1;
        bus.a = ia; bus.b = ib; bus.cin = icin; bus.sub = isub;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm, output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bus.out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk({nm, "_latency"}, 32'(lat), 32'(NC));
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic icin, input logic isub,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        int lat;
        chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        start_op(ia, ib, icin, isub);
        wait_done(nm, lat);
        chk({nm, "_sum"},      32'(bus.sum),      32'(es));
        chk({nm, "_cout"},     32'(bus.cout),     32'(ec));
        chk({nm, "_overflow"}, 32'(bus.overflow), 32'(eo));
        tick();
        chk({nm, "_released"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
        bus.cin = 1'b0; bus.sub = 1'b0; bus.out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum",       32'(bus.sum),       32'd0);
        chk("rst_cout",      32'(bus.cout),      32'd0);
        chk("rst_overflow",  32'(bus.overflow),  32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        run_op("basic_add", 16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0);
        run_op("ripple",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("sub_pos",   16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
        run_op("sub_neg",   16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("ovf_add",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("ovf_sub",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Backpressure: result held while a new op is offered.
        bus.out_ready = 1'b0;
        start_op(16'h00F0, 16'h0010, 1'b0, 1'b0);
        wait_done("bp", lat);
        chk("bp_sum", 32'(bus.sum), 32'h0100);
        bus.in_valid = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222;
        bus.cin = 1'b0; bus.sub = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_ready", 32'(bus.in_ready),  32'd0);
            chk("bp_hold_sum",   32'(bus.sum),       32'h0100);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_busy",  32'(bus.busy),     32'd0);
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        tick();
        chk("bp_accept_busy", 32'(bus.busy), 32'd1);
        bus.in_valid = 1'b0;
        wait_done("bp_next", lat);
        chk("bp_next_sum", 32'(bus.sum), 32'h3333);
        tick();

        // Reset two RUN cycles into an operation.
        start_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_sum",       32'(bus.sum),       32'd0);
        chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("midrst_busy",      32'(bus.busy),      32'd0);
        run_op("after_rst", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
